// File: rtl/crc_engine_param.sv
// Parametrised streaming CRC engine: MSB-first, non-reflected, one result per frame.
// Optional CRC_CHK_EN macro adds the crc_exp input and the registered crc_err compare.
module crc_engine_param #(
    parameter int               DATA_W  = 8,
    parameter int               CRC_W   = 8,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(8'h07),
    parameter logic [CRC_W-1:0] INIT    = CRC_W'(8'hFF),
    parameter logic [CRC_W-1:0] XOR_OUT = CRC_W'(8'h00)
) (
    input  logic                 clk_sys,
    input  logic                 rst_sys,
    input  logic [DATA_W-1:0]    crc_din,
    input  logic                 crc_din_vld,
    input  logic                 crc_sop,
    input  logic                 crc_eop,
    input  logic [DATA_W/8-1:0]  crc_be,
`ifdef CRC_CHK_EN
    input  logic [CRC_W-1:0]     crc_exp,
    output logic                 crc_err,
`endif
    output logic [CRC_W-1:0]     crc_dout,
    output logic                 crc_dout_vld,
    output logic [15:0]          crc_byte_cnt,
    output logic                 crc_busy
);
    localparam int NB = DATA_W / 8;
    localparam int NW = $clog2(NB + 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                   state, state_nxt;
    logic [CRC_W-1:0]         crc_reg, crc_nxt;
    logic [15:0]              cnt, cnt_base, cnt_nxt;
    logic [16:0]              cnt_sum;
    logic [NB-1:0][7:0]       beat;
    logic [NB:0][CRC_W-1:0]   stage;
    logic [NW-1:0]            be_cnt, n_bytes;
    logic                     run, load, issue;

    // One byte, bit 7 first; feedback is register MSB xor data bit.
    function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c,
                                                  input logic [7:0] d);
        logic [CRC_W-1:0] r;
        r = c;
        for (int i = 7; i >= 0; i--)
            r = {r[CRC_W-2:0], 1'b0} ^ ((r[CRC_W-1] ^ d[i]) ? POLY : '0);
        return r;
    endfunction

    assign beat = crc_din;

    // stage[k] is the register after the first k bytes of this beat (MSB byte first).
    always_comb begin
        stage    = '0;
        stage[0] = crc_sop ? INIT : crc_reg;
        for (int k = 0; k < NB; k++)
            stage[k+1] = crc_byte(stage[k], beat[NB-1-k]);
    end

    // Leading ones of crc_be from the MSB; zero means the whole beat.
    always_comb begin
        be_cnt = '0;
        run    = 1'b1;
        for (int i = NB - 1; i >= 0; i--) begin
            if (run && crc_be[i]) be_cnt = be_cnt + NW'(1);
            else                  run    = 1'b0;
        end
        if (crc_be == '0) be_cnt = NW'(NB);
    end

    assign n_bytes  = crc_eop ? be_cnt : NW'(NB);
    assign crc_nxt  = stage[n_bytes];
    assign cnt_base = crc_sop ? 16'h0000 : cnt;
    assign cnt_sum  = {1'b0, cnt_base} + 17'(n_bytes);
    assign cnt_nxt  = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    assign crc_busy = (state == ACCUM);

    // A sop beat always restarts, so an open frame is simply dropped on re-sop.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        issue     = 1'b0;
        if (crc_din_vld && (crc_sop || state == ACCUM)) begin
            if (crc_eop) begin
                issue     = 1'b1;
                state_nxt = IDLE;
            end else begin
                load      = 1'b1;
                state_nxt = ACCUM;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            state        <= IDLE;
            crc_reg      <= INIT;
            cnt          <= '0;
            crc_dout     <= '0;
            crc_dout_vld <= 1'b0;
            crc_byte_cnt <= '0;
`ifdef CRC_CHK_EN
            crc_err      <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            crc_dout_vld <= issue;
            if (load) begin
                crc_reg <= crc_nxt;
                cnt     <= cnt_nxt;
            end else if (issue) begin
                crc_reg <= INIT;
                cnt     <= '0;
            end
            if (issue) begin
                crc_dout     <= crc_nxt ^ XOR_OUT;
                crc_byte_cnt <= cnt_nxt;
`ifdef CRC_CHK_EN
                crc_err      <= ((crc_nxt ^ XOR_OUT) != crc_exp);
`endif
            end
        end
    end
endmodule

// File: tb/tb_crc_engine_param.sv
// Directed bench for crc_engine_param: 8-, 16- and 32-bit beat instances, default CRC-8.
module tb_crc_engine_param;
    logic clk_sys = 1'b0;
    logic rst_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic [7:0]  d8 = '0;  logic v8 = 0, s8 = 0, e8 = 0; logic [0:0] b8 = '0;
    logic [15:0] d16 = '0; logic v16 = 0, s16 = 0, e16 = 0; logic [1:0] b16 = '0;
    logic [31:0] d32 = '0; logic v32 = 0, s32 = 0, e32 = 0; logic [3:0] b32 = '0;

    logic [7:0]  q8, q16, q32;
    logic        qv8, qv16, qv32, bz8, bz16, bz32;
    logic [15:0] c8, c16, c32;
`ifdef CRC_CHK_EN
    logic [7:0]  x8 = '0, x16 = '0, x32 = '0;
    logic        r8, r16, r32;
`endif

    crc_engine_param #(.DATA_W(8)) u8 (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .crc_din(d8), .crc_din_vld(v8),
        .crc_sop(s8), .crc_eop(e8), .crc_be(b8),
`ifdef CRC_CHK_EN
        .crc_exp(x8), .crc_err(r8),
`endif
        .crc_dout(q8), .crc_dout_vld(qv8), .crc_byte_cnt(c8), .crc_busy(bz8));

    crc_engine_param #(.DATA_W(16)) u16 (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .crc_din(d16), .crc_din_vld(v16),
        .crc_sop(s16), .crc_eop(e16), .crc_be(b16),
`ifdef CRC_CHK_EN
        .crc_exp(x16), .crc_err(r16),
`endif
        .crc_dout(q16), .crc_dout_vld(qv16), .crc_byte_cnt(c16), .crc_busy(bz16));

    crc_engine_param #(.DATA_W(32)) u32 (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .crc_din(d32), .crc_din_vld(v32),
        .crc_sop(s32), .crc_eop(e32), .crc_be(b32),
`ifdef CRC_CHK_EN
        .crc_exp(x32), .crc_err(r32),
`endif
        .crc_dout(q32), .crc_dout_vld(qv32), .crc_byte_cnt(c32), .crc_busy(bz32));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One beat on the selected instance; returns #1 after the clock edge that took it.
    task automatic drive(input int sel, input logic [31:0] d, input logic sop,
                         input logic eop, input logic [3:0] be);
        case (sel)
            8:  begin d8  = d[7:0];  s8  = sop; e8  = eop; b8  = be[0:0]; v8  = 1'b1; end
            16: begin d16 = d[15:0]; s16 = sop; e16 = eop; b16 = be[1:0]; v16 = 1'b1; end
            default: begin d32 = d; s32 = sop; e32 = eop; b32 = be; v32 = 1'b1; end
        endcase
        @(posedge clk_sys); #1;
        v8 = 1'b0; v16 = 1'b0; v32 = 1'b0;
        s8 = 1'b0; s16 = 1'b0; s32 = 1'b0;
        e8 = 1'b0; e16 = 1'b0; e32 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk_sys);
        #1;
        check("rst_dout",  32'(q8),   32'h0);
        check("rst_vld",   32'(qv8),  32'h0);
        check("rst_cnt",   32'(c8),   32'h0);
        check("rst_busy",  32'(bz8),  32'h0);
        check("rst_vld32", 32'(qv32), 32'h0);
        rst_sys = 1'b1;
        idle(1);

        // 8-bit beats
        drive(8, 32'h00, 1, 1, 4'h1);
        check("b8_00_vld", 32'(qv8), 32'h1);
        check("b8_00_crc", 32'(q8),  32'hF3);
        check("b8_00_cnt", 32'(c8),  32'd1);
        idle(1);
        check("b8_pulse",  32'(qv8), 32'h0);
        check("b8_hold",   32'(q8),  32'hF3);
        drive(8, 32'hFF, 1, 1, 4'h1);
        check("b8_ff_crc", 32'(q8),  32'h00);
        drive(8, 32'h00, 1, 0, 4'h1);
        check("b8_busy",   32'(bz8), 32'h1);
        check("b8_novld",  32'(qv8), 32'h0);
        idle(2);
        drive(8, 32'h00, 0, 1, 4'h1);
        check("b8_gap_vld", 32'(qv8), 32'h1);
        check("b8_gap_crc", 32'(q8),  32'hD7);
        check("b8_gap_cnt", 32'(c8),  32'd2);
        check("b8_idle",    32'(bz8), 32'h0);
        drive(8, 32'h55, 0, 1, 4'h1);
        check("b8_nosop_vld", 32'(qv8), 32'h0);
        check("b8_nosop_crc", 32'(q8),  32'hD7);
        check("b8_nosop_bsy", 32'(bz8), 32'h0);

        // 16-bit beats: byte-enable decode on the eop beat
        drive(16, 32'h0000, 1, 1, 4'b0011);
        check("b16_be11_crc", 32'(q16), 32'hD7);
        check("b16_be11_cnt", 32'(c16), 32'd2);
        drive(16, 32'h0000, 1, 1, 4'b0010);
        check("b16_be10_crc", 32'(q16), 32'hF3);
        check("b16_be10_cnt", 32'(c16), 32'd1);
        drive(16, 32'h0000, 1, 1, 4'b0000);
        check("b16_be00_crc", 32'(q16), 32'hD7);
        check("b16_be00_cnt", 32'(c16), 32'd2);

        // 32-bit beats: abandon, restart and back-to-back
        drive(32, 32'hFFFF_FFFF, 1, 0, 4'hF);
        check("b32_busy", 32'(bz32), 32'h1);
        drive(32, 32'h0000_0000, 1, 0, 4'hF);
        check("b32_abandon_vld", 32'(qv32), 32'h0);
        drive(32, 32'h0000_0000, 0, 1, 4'b1000);
        check("b32_restart_crc", 32'(q32), 32'h39);
        check("b32_restart_cnt", 32'(c32), 32'd5);
        drive(32, 32'hFFFF_FFFF, 1, 0, 4'hF);
        drive(32, 32'h0000_0000, 1, 1, 4'hF);
        check("b32_se_vld", 32'(qv32), 32'h1);
        check("b32_se_crc", 32'(q32),  32'hD1);
        check("b32_se_cnt", 32'(c32),  32'd4);
        drive(32, 32'hFF00_0000, 1, 1, 4'b1000);
        check("b32_b2b_vld", 32'(qv32), 32'h1);
        check("b32_b2b_crc", 32'(q32),  32'h00);
        check("b32_b2b_cnt", 32'(c32),  32'd1);

        // 65536 bytes must saturate the count
        drive(32, 32'h0, 1, 0, 4'hF);
        for (int i = 0; i < 16382; i++) drive(32, 32'h0, 0, 0, 4'hF);
        drive(32, 32'h0, 0, 1, 4'hF);
        check("b32_sat_cnt", 32'(c32), 32'hFFFF);

`ifdef CRC_CHK_EN
        x8 = 8'hF3;
        drive(8, 32'h00, 1, 1, 4'h1);
        check("chk_ok",  32'(r8), 32'h0);
        x8 = 8'hF2;
        drive(8, 32'h00, 1, 1, 4'h1);
        check("chk_bad", 32'(r8), 32'h1);
        idle(1);
        check("chk_hold", 32'(r8), 32'h1);
`endif

        // reset in the middle of a frame
        drive(8, 32'h00, 1, 1, 4'h1);
        drive(8, 32'h00, 1, 0, 4'h1);
        rst_sys = 1'b0;
        #1;
        check("mrst_dout", 32'(q8),  32'h0);
        check("mrst_cnt",  32'(c8),  32'h0);
        check("mrst_busy", 32'(bz8), 32'h0);
        check("mrst_vld",  32'(qv8), 32'h0);
        idle(1);
        rst_sys = 1'b1;
        idle(1);
        drive(8, 32'h00, 0, 1, 4'h1);
        check("mrst_drop", 32'(qv8), 32'h0);
        drive(8, 32'h00, 1, 1, 4'h1);
        check("mrst_after_crc", 32'(q8), 32'hF3);
        check("mrst_after_cnt", 32'(c8), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
